// File: rtl/i2s_audio_ctrl.sv
// I2S bus master for the SGTL5000 codec: derives BCLK/LRCLK from the system clock,
// shifts one stereo pair out and one stereo pair in per 64-slot Philips I2S frame.
module i2s_audio_ctrl #(
   parameter int BCLK_HALF = 8,
   parameter int SAMPLE_W  = 16
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] tx_left,
   input  logic [SAMPLE_W-1:0] tx_right,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic [SAMPLE_W-1:0] rx_left,
   output logic [SAMPLE_W-1:0] rx_right,
   output logic                rx_valid,
   output logic                underrun,
   input  logic                clr_underrun,
   output logic                i2s_bclk,
   output logic                i2s_lrclk,
   output logic                i2s_dout,
   input  logic                i2s_din
);

   localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam int IDX_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(BCLK_HALF - 1);
   localparam logic [5:0]       LEFT_LAST   = 6'(SAMPLE_W);
   localparam logic [5:0]       RIGHT_FIRST = 6'd33;
   localparam logic [5:0]       RIGHT_LAST  = 6'(32 + SAMPLE_W);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state, state_nxt;
   logic [DIV_W-1:0]    div_cnt;
   logic [5:0]          bit_cnt, bit_nxt;
   logic [SAMPLE_W-1:0] pending_left, pending_right;
   logic                pending_full;
   logic [SAMPLE_W-1:0] frame_left, frame_right;
   logic [SAMPLE_W-1:0] shift_left, shift_right;
   logic                running, div_wrap, rise_evt, fall_evt, load_evt;
   logic                slot_bit, in_left, in_right;
   logic [IDX_W-1:0]    left_idx, right_idx;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable)  state_nxt = RUN;
         RUN:     if (!enable) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign running   = (state == RUN) && enable;
   assign div_wrap  = running && (div_cnt == DIV_LAST);
   assign rise_evt  = div_wrap && !i2s_bclk;
   assign fall_evt  = div_wrap && i2s_bclk;
   assign bit_nxt   = bit_cnt + 6'd1;
   assign load_evt  = fall_evt && (bit_nxt == 6'd0);
   assign left_idx  = IDX_W'(LEFT_LAST - bit_nxt);
   assign right_idx = IDX_W'(RIGHT_LAST - bit_nxt);
   assign in_left   = (bit_cnt >= 6'd1) && (bit_cnt <= LEFT_LAST);
   assign in_right  = (bit_cnt >= RIGHT_FIRST) && (bit_cnt <= RIGHT_LAST);
   assign tx_ready  = ~pending_full;

   // Data bit for the slot that begins at this falling edge, MSB first after the LRCLK change
   always_comb begin
      slot_bit = 1'b0;
      if ((bit_nxt >= 6'd1) && (bit_nxt <= LEFT_LAST))
         slot_bit = frame_left[left_idx];
      else if ((bit_nxt >= RIGHT_FIRST) && (bit_nxt <= RIGHT_LAST))
         slot_bit = frame_right[right_idx];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         div_cnt       <= '0;
         bit_cnt       <= 6'd63;
         i2s_bclk      <= 1'b0;
         i2s_lrclk     <= 1'b0;
         i2s_dout      <= 1'b0;
         frame_left    <= '0;
         frame_right   <= '0;
         shift_left    <= '0;
         shift_right   <= '0;
         pending_left  <= '0;
         pending_right <= '0;
         pending_full  <= 1'b0;
         underrun      <= 1'b0;
         rx_left       <= '0;
         rx_right      <= '0;
         rx_valid      <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (running) begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            if (div_wrap) i2s_bclk <= ~i2s_bclk;
            if (fall_evt) begin
               bit_cnt   <= bit_nxt;
               i2s_lrclk <= bit_nxt[5];
               i2s_dout  <= slot_bit;
            end
            if (load_evt) begin
               frame_left  <= pending_full ? pending_left  : '0;
               frame_right <= pending_full ? pending_right : '0;
            end
            if (rise_evt) begin
               if (in_left)  shift_left  <= {shift_left[SAMPLE_W-2:0], i2s_din};
               if (in_right) shift_right <= {shift_right[SAMPLE_W-2:0], i2s_din};
               if (bit_cnt == RIGHT_LAST) begin
                  rx_left  <= shift_left;
                  rx_right <= {shift_right[SAMPLE_W-2:0], i2s_din};
                  rx_valid <= 1'b1;
               end
            end
         end else begin
            // Leaving or idling outside RUN: restart the frame cleanly, drop partial rx data
            div_cnt     <= '0;
            bit_cnt     <= 6'd63;
            i2s_bclk    <= 1'b0;
            i2s_lrclk   <= 1'b0;
            i2s_dout    <= 1'b0;
            shift_left  <= '0;
            shift_right <= '0;
         end

         if (tx_valid && !pending_full) begin
            pending_left  <= tx_left;
            pending_right <= tx_right;
            pending_full  <= 1'b1;
         end else if (load_evt) begin
            pending_full <= 1'b0;
         end

         if (load_evt && !pending_full) underrun <= 1'b1;
         else if (clr_underrun)         underrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_i2s_audio_ctrl.sv
// Self-checking bench for i2s_audio_ctrl: loopback (din = dout), table-driven frames,
// directed corner sequences and a randomized run against a frame-level reference model.
module tb_i2s_audio_ctrl;

   localparam int H = 8;
   localparam int W = 16;

   logic          Clk = 1'b0;
   logic          Reset_n, enable, tx_valid, clr_underrun;
   logic [W-1:0]  tx_left, tx_right;
   logic          tx_ready, rx_valid, underrun;
   logic [W-1:0]  rx_left, rx_right;
   logic          i2s_bclk, i2s_lrclk, i2s_dout, i2s_din;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit mon_on   = 1'b0;

   i2s_audio_ctrl #(.BCLK_HALF(H), .SAMPLE_W(W)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .enable(enable),
      .tx_left(tx_left), .tx_right(tx_right), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_left(rx_left), .rx_right(rx_right), .rx_valid(rx_valid),
      .underrun(underrun), .clr_underrun(clr_underrun),
      .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_dout(i2s_dout), .i2s_din(i2s_din)
   );

   assign i2s_din = i2s_dout;

   always #10 Clk = ~Clk;

   initial forever begin
      @(posedge Clk);
      cyc++;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference model: time in RUN counted in Clks, everything else derived arithmetically
   bit           m_run, m_pf, m_und, m_rxv;
   int           m_n;
   logic [W-1:0] m_pl, m_pr, m_fl, m_fr, m_rxl, m_rxr;

   function automatic bit slotBit(input int k, input logic [W-1:0] l, input logic [W-1:0] r);
      if (k >= 1 && k <= W)           return l[W-k];
      if (k >= 33 && k <= 32 + W)     return r[32+W-k];
      return 1'b0;
   endfunction

   initial begin : model
      int n1, h, bc;
      bit load, strobe, accept;
      forever begin
         @(posedge Clk or negedge Reset_n);
         if (!Reset_n) begin
            m_run = 0; m_n = 0; m_pf = 0; m_und = 0; m_rxv = 0;
            m_pl = 0; m_pr = 0; m_fl = 0; m_fr = 0; m_rxl = 0; m_rxr = 0;
         end else begin
            load = 0; strobe = 0;
            if (m_run && enable) begin
               n1 = m_n + 1;
               if (n1 % H == 0) begin
                  h  = n1 / H;
                  bc = (h / 2 + 63) % 64;
                  if (h % 2 == 0 && bc == 0)      load = 1;
                  if (h % 2 == 1 && bc == 32 + W) strobe = 1;
               end
            end
            m_rxv = strobe;
            if (strobe) begin m_rxl = m_fl; m_rxr = m_fr; end
            if (clr_underrun)   m_und = 0;
            if (load && !m_pf)  m_und = 1;
            accept = tx_valid && !m_pf;
            if (load) begin
               m_fl = m_pf ? m_pl : '0;
               m_fr = m_pf ? m_pr : '0;
               m_pf = 0;
            end
            if (accept) begin m_pl = tx_left; m_pr = tx_right; m_pf = 1; end
            if (!m_run && enable)      begin m_run = 1; m_n = 0; end
            else if (m_run && !enable) begin m_run = 0; m_n = 0; end
            else if (m_run)            m_n = m_n + 1;
         end
      end
   end

   initial begin : monitor
      int h, bc;
      bit eb, el, ed;
      forever begin
         @(negedge Clk);
         if (Reset_n && mon_on) begin
            h = m_n / H;
            eb = m_run ? h[0] : 1'b0;
            el = 0; ed = 0;
            if (m_run && h >= 2) begin
               bc = (h / 2 + 63) % 64;
               el = (bc >= 32);
               ed = slotBit(bc, m_fl, m_fr);
            end
            checkOutput("model_bus", {58'd0, i2s_bclk, i2s_lrclk, i2s_dout, tx_ready, underrun, rx_valid},
                        {58'd0, eb, el, ed, !m_pf, m_und, m_rxv});
            if (m_rxv)
               checkOutput("model_rx", {32'd0, rx_left, rx_right}, {32'd0, m_rxl, m_rxr});
         end
      end
   end

   task automatic applyStimulus(input logic [W-1:0] l, input logic [W-1:0] r);
      int budget = 0;
      while (tx_ready !== 1'b1 && budget < 3000) begin
         @(negedge Clk);
         budget++;
      end
      checkOutput("offer_timeout", {63'd0, tx_ready}, 64'd1);
      tx_left = l; tx_right = r; tx_valid = 1'b1;
      @(negedge Clk);
      tx_valid = 1'b0;
   endtask

   // Collect the 64 slot bits of one frame at BCLK rises, plus its rx strobe
   task automatic captureFrame(input bit first, output logic [63:0] bits,
                               output logic [W-1:0] rl, output logic [W-1:0] rr,
                               output bit got, output int strobe_cyc);
      int budget = 0;
      int rises  = 0;
      int skip;
      bit prev;
      bits = '0; rl = '0; rr = '0; got = 0; strobe_cyc = -1;
      if (!first) begin
         while (i2s_lrclk !== 1'b1 && budget < 3000) begin @(negedge Clk); budget++; end
         while (i2s_lrclk !== 1'b0 && budget < 3000) begin @(negedge Clk); budget++; end
      end
      skip = first ? 1 : 0;
      prev = i2s_bclk;
      while (rises < 64 + skip && budget < 3000) begin
         @(negedge Clk);
         budget++;
         if (rx_valid) begin got = 1; rl = rx_left; rr = rx_right; strobe_cyc = cyc; end
         if (i2s_bclk && !prev) begin
            if (rises >= skip) bits = {bits[62:0], i2s_dout};
            rises++;
         end
         prev = i2s_bclk;
      end
      checkOutput("frame_timeout", {63'd0, budget < 3000}, 64'd1);
   endtask

   typedef struct {
      logic [W-1:0] l, r;
      bit           offer;
      logic [63:0]  exp_bits;
      logic [W-1:0] exp_rxl, exp_rxr;
      bit           exp_und;
   } vec_t;

   vec_t vecs[5];

   initial begin : main
      logic [63:0]  bits;
      logic [W-1:0] rl, rr;
      bit           got, saw;
      int           sc, last_sc, budget, rises;
      bit           prev;

      vecs[0] = '{16'hA5C3, 16'h3C5A, 1, {1'b0, 16'hA5C3, 16'h0000, 16'h3C5A, 15'h0}, 16'hA5C3, 16'h3C5A, 0};
      vecs[1] = '{16'h1234, 16'hFEDC, 1, {1'b0, 16'h1234, 16'h0000, 16'hFEDC, 15'h0}, 16'h1234, 16'hFEDC, 0};
      vecs[2] = '{16'h8000, 16'h7FFF, 1, {1'b0, 16'h8000, 16'h0000, 16'h7FFF, 15'h0}, 16'h8000, 16'h7FFF, 0};
      vecs[3] = '{16'h0000, 16'h0000, 0, 64'd0, 16'h0000, 16'h0000, 1};
      vecs[4] = '{16'hFFFF, 16'h0001, 1, {1'b0, 16'hFFFF, 16'h0000, 16'h0001, 15'h0}, 16'hFFFF, 16'h0001, 1};

      Reset_n = 1'b0; enable = 1'b1; tx_valid = 1'b0; clr_underrun = 1'b0;
      tx_left = '0; tx_right = '0;
      repeat (4) @(negedge Clk);
      checkOutput("reset_bus", {61'd0, i2s_bclk, i2s_lrclk, i2s_dout}, 64'd0);
      checkOutput("reset_rx_valid", {63'd0, rx_valid}, 64'd0);
      checkOutput("reset_underrun", {63'd0, underrun}, 64'd0);
      checkOutput("reset_tx_ready", {63'd0, tx_ready}, 64'd1);
      checkOutput("reset_rx_data", {32'd0, rx_left, rx_right}, 64'd0);

      enable = 1'b0;
      Reset_n = 1'b1;
      mon_on = 1'b1;
      saw = 0;
      repeat (40) begin
         @(negedge Clk);
         if (i2s_bclk || i2s_lrclk || i2s_dout) saw = 1;
      end
      checkOutput("idle_bus_quiet", {63'd0, saw}, 64'd0);

      last_sc = -1;
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].offer) begin
            applyStimulus(vecs[i].l, vecs[i].r);
            checkOutput($sformatf("v%0d_pending_ready", i), {63'd0, tx_ready}, 64'd0);
         end
         if (i == 0) enable = 1'b1;
         captureFrame(i == 0, bits, rl, rr, got, sc);
         checkOutput($sformatf("v%0d_slots", i), bits, vecs[i].exp_bits);
         checkOutput($sformatf("v%0d_rx_strobe", i), {63'd0, got}, 64'd1);
         checkOutput($sformatf("v%0d_rx_pair", i), {32'd0, rl, rr}, {32'd0, vecs[i].exp_rxl, vecs[i].exp_rxr});
         checkOutput($sformatf("v%0d_underrun", i), {63'd0, underrun}, {63'd0, vecs[i].exp_und});
         checkOutput($sformatf("v%0d_ready_after_load", i), {63'd0, tx_ready}, 64'd1);
         if (i >= 1)
            checkOutput($sformatf("v%0d_strobe_period", i), 64'(sc - last_sc), 64'd1024);
         last_sc = sc;
      end

      // Underrun set coinciding with clr_underrun: set must win
      clr_underrun = 1'b1;
      budget = 0;
      while (i2s_lrclk !== 1'b1 && budget < 3000) begin @(negedge Clk); budget++; end
      while (i2s_lrclk !== 1'b0 && budget < 3000) begin @(negedge Clk); budget++; end
      clr_underrun = 1'b0;
      checkOutput("clr_collision_timeout", {63'd0, budget < 3000}, 64'd1);
      checkOutput("clr_collision_underrun", {63'd0, underrun}, 64'd1);
      applyStimulus(16'h5A5A, 16'hC3C3);
      clr_underrun = 1'b1;
      @(negedge Clk);
      clr_underrun = 1'b0;
      checkOutput("clr_alone_underrun", {63'd0, underrun}, 64'd0);

      // Mid-frame disable at bit_cnt 20 with a pair left pending
      budget = 0;
      while (i2s_lrclk !== 1'b1 && budget < 3000) begin @(negedge Clk); budget++; end
      while (i2s_lrclk !== 1'b0 && budget < 3000) begin @(negedge Clk); budget++; end
      applyStimulus(16'hBEEF, 16'h0F0F);
      rises = 0;
      prev = i2s_bclk;
      while (rises < 21 && budget < 3000) begin
         @(negedge Clk);
         budget++;
         if (i2s_bclk && !prev) rises++;
         prev = i2s_bclk;
      end
      checkOutput("disable_point_timeout", {63'd0, budget < 3000}, 64'd1);
      enable = 1'b0;
      @(negedge Clk);
      checkOutput("disable_bus", {61'd0, i2s_bclk, i2s_lrclk, i2s_dout}, 64'd0);
      saw = 0;
      repeat (300) begin
         @(negedge Clk);
         if (rx_valid || i2s_bclk || i2s_lrclk || i2s_dout) saw = 1;
      end
      checkOutput("disable_quiet", {63'd0, saw}, 64'd0);
      checkOutput("disable_keeps_pending", {63'd0, tx_ready}, 64'd0);
      enable = 1'b1;
      captureFrame(1, bits, rl, rr, got, sc);
      checkOutput("restart_slots", bits, {1'b0, 16'hBEEF, 16'h0000, 16'h0F0F, 15'h0});
      checkOutput("restart_rx_pair", {32'd0, rl, rr}, {32'd0, 16'hBEEF, 16'h0F0F});
      checkOutput("restart_rx_strobe", {63'd0, got}, 64'd1);

      // Randomized traffic, enable drops and clears against the model
      for (int c = 0; c < 12000; c++) begin
         @(negedge Clk);
         tx_valid     = ($urandom_range(0, 5) == 0);
         tx_left      = W'($urandom);
         tx_right     = W'($urandom);
         clr_underrun = ($urandom_range(0, 150) == 0);
         if (enable && $urandom_range(0, 2500) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(0, 30) == 0) enable = 1'b1;
      end
      tx_valid = 1'b0; clr_underrun = 1'b0;
      repeat (4) @(negedge Clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
